udm_bus_decoder: RTL and testbench

- Address decoder and response router placed directly downstream of the udm bus master.
- Fans one master request port (req/ack/addr/we/wdata/be, resp/rdata) out to N_SLAVES slave ports.
- Tracks outstanding reads in an in-order FIFO and steers each slave's read response back to the master.
- Answers accesses to unmapped addresses itself, so the master never waits for its bus timeout.

---
 rtl/udm_bus_decoder.sv | 107 ++++++++++
 tb/tb_udm_bus_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/udm_bus_decoder.sv
// udm_bus_decoder: fans the udm master out to N slaves and routes in-order read responses back
module udm_bus_decoder #(
    parameter int                      N_SLAVES        = 4,
    parameter logic [32*N_SLAVES-1:0]  SLAVE_BASE      = {32'h80000000, 32'h00001000, 32'h00000100, 32'h00000000},
    parameter logic [32*N_SLAVES-1:0]  SLAVE_MASK      = {32'hFFFFF000, 32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFFFF0},
    parameter int                      MAX_OUTSTANDING = 4,
    parameter logic [31:0]             ERR_RDATA       = 32'hDEADBEEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    m_req_i,
    input  logic                    m_we_i,
    input  logic [31:0]             m_addr_bi,
    input  logic [3:0]              m_be_bi,
    input  logic [31:0]             m_wdata_bi,
    output logic                    m_ack_o,
    output logic                    m_resp_o,
    output logic [31:0]             m_rdata_bo,
    output logic [N_SLAVES-1:0]     s_req_bo,
    output logic                    s_we_o,
    output logic [31:0]             s_addr_bo,
    output logic [3:0]              s_be_bo,
    output logic [31:0]             s_wdata_bo,
    input  logic [N_SLAVES-1:0]     s_ack_bi,
    input  logic [N_SLAVES-1:0]     s_resp_bi,
    input  logic [32*N_SLAVES-1:0]  s_rdata_bi,
    output logic                    err_o,
    output logic                    unmapped_o
);
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int CW = AW + 1;
    localparam int EW = $clog2(N_SLAVES + 1);
    localparam logic [EW-1:0] UNM = EW'(N_SLAVES);

    logic [EW-1:0]       mem [MAX_OUTSTANDING];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic [N_SLAVES-1:0] win, hmask;
    logic [EW-1:0]       sel, head;
    logic [31:0]         hdata;
    logic                hit, full, empty, ok, push, pop, head_unm, hresp, bad;

    assign s_we_o     = m_we_i;
    assign s_addr_bo  = m_addr_bi;
    assign s_be_bo    = m_be_bi;
    assign s_wdata_bo = m_wdata_bi;
    assign full       = count == CW'(MAX_OUTSTANDING);
    assign empty      = count == '0;
    assign head       = mem[rd_ptr];

    // address decode: scan downwards so the lowest matching slave index wins
    always_comb begin
        win = '0;
        sel = UNM;
        for (int i = N_SLAVES - 1; i >= 0; i--)
            if ((m_addr_bi & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                win = '0;
                win[i] = 1'b1;
                sel = EW'(i);
            end
        hit = |win;
    end

    // request path: writes never need a FIFO slot, reads stall while the tracker is full
    always_comb begin
        ok         = m_we_i | ~full;
        s_req_bo   = win & {N_SLAVES{m_req_i & ok}};
        m_ack_o    = hit ? (|(win & s_ack_bi) & ok) : (m_req_i & ok);
        push       = m_req_i & m_ack_o & ~m_we_i;
        unmapped_o = m_req_i & m_ack_o & ~hit;
    end

    // response path: route the head slave's response, or answer an unmapped read from the registered head
    always_comb begin
        hmask = '0;
        hdata = '0;
        for (int j = 0; j < N_SLAVES; j++)
            if (!empty && head == EW'(j)) begin
                hmask[j] = 1'b1;
                hdata = s_rdata_bi[32*j +: 32];
            end
        head_unm   = ~empty & (head == UNM);
        hresp      = |(s_resp_bi & hmask);
        m_resp_o   = head_unm | hresp;
        m_rdata_bo = head_unm ? ERR_RDATA : hresp ? hdata : '0;
        pop        = m_resp_o;
        bad        = |(s_resp_bi & ~hmask);
    end

    // tracker pointers, occupancy and the sticky protocol error
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_o  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            err_o <= err_o | bad;
        end

    // tracker storage holds the target slave index (or the unmapped tag) of each accepted read
    always_ff @(posedge clk_i)
        if (push) mem[wr_ptr] <= sel;
endmodule

// File: tb/tb_udm_bus_decoder.sv
// tb_udm_bus_decoder: directed checks of decode, read tracking, unmapped answers and error handling
module tb_udm_bus_decoder;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         m_req_i, m_we_i;
    logic [31:0]  m_addr_bi, m_wdata_bi;
    logic [3:0]   m_be_bi;
    logic         m_ack_o, m_resp_o;
    logic [31:0]  m_rdata_bo;
    logic [3:0]   s_req_bo;
    logic         s_we_o;
    logic [31:0]  s_addr_bo, s_wdata_bo;
    logic [3:0]   s_be_bo;
    logic [3:0]   s_ack_bi, s_resp_bi;
    logic [127:0] s_rdata_bi;
    logic         err_o, unmapped_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] q[$];

    udm_bus_decoder dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_bi(m_addr_bi), .m_be_bi(m_be_bi),
        .m_wdata_bi(m_wdata_bi), .m_ack_o(m_ack_o), .m_resp_o(m_resp_o), .m_rdata_bo(m_rdata_bo),
        .s_req_bo(s_req_bo), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo), .s_be_bo(s_be_bo),
        .s_wdata_bo(s_wdata_bo), .s_ack_bi(s_ack_bi), .s_resp_bi(s_resp_bi), .s_rdata_bi(s_rdata_bi),
        .err_o(err_o), .unmapped_o(unmapped_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_resp(input string tag);
        logic [31:0] e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=response expected=none_queued", tag);
        end else begin
            e = q.pop_front();
            chk({tag, "_resp"}, 32'(m_resp_o), 32'd1);
            chk({tag, "_data"}, m_rdata_bo, e);
        end
    endtask

    initial begin
        rst_i = 1'b1; m_req_i = 0; m_we_i = 0; m_addr_bi = 0; m_be_bi = 0; m_wdata_bi = 0;
        s_ack_bi = 0; s_resp_bi = 0; s_rdata_bi = 0;
        tick; tick; rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_resp", 32'(m_resp_o), 0);
        chk("rst_rdata", m_rdata_bo, 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_unm", 32'(unmapped_o), 0);
        chk("rst_count", 32'(dut.count), 0);
        tick;
        m_req_i = 1; m_we_i = 1; m_addr_bi = 32'h0000000C; m_wdata_bi = 32'h1234; m_be_bi = 4'h3; s_ack_bi = 4'b0001;
        @(negedge clk_i);
        chk("wr_sreq", 32'(s_req_bo), 4'b0001);
        chk("wr_ack", 32'(m_ack_o), 1);
        chk("wr_wdata", s_wdata_bo, 32'h1234);
        chk("wr_addr", s_addr_bo, 32'hC);
        chk("wr_be", 32'(s_be_bo), 4'h3);
        chk("wr_we", 32'(s_we_o), 1);
        chk("wr_unm", 32'(unmapped_o), 0);
        tick; m_req_i = 0; m_we_i = 0; s_ack_bi = 0;
        @(negedge clk_i);
        chk("wr_count", 32'(dut.count), 0);
        tick;
        m_req_i = 1; m_we_i = 1; m_addr_bi = 32'h40000000;
        @(negedge clk_i);
        chk("uwr_ack", 32'(m_ack_o), 1);
        chk("uwr_unm", 32'(unmapped_o), 1);
        chk("uwr_sreq", 32'(s_req_bo), 0);
        tick; m_req_i = 0; m_we_i = 0;
        @(negedge clk_i);
        chk("uwr_count", 32'(dut.count), 0);
        chk("uwr_resp", 32'(m_resp_o), 0);
        tick;
        m_req_i = 1; m_addr_bi = 32'h80000010; s_ack_bi = 4'b1000;
        @(negedge clk_i);
        chk("rd3_sreq", 32'(s_req_bo), 4'b1000);
        chk("rd3_ack", 32'(m_ack_o), 1);
        q.push_back(32'hCAFEF00D);
        tick; m_req_i = 0; s_ack_bi = 0;
        @(negedge clk_i);
        chk("rd3_count", 32'(dut.count), 1);
        chk("rd3_wait", 32'(m_resp_o), 0);
        tick; s_resp_bi = 4'b1000; s_rdata_bi[127:96] = 32'hCAFEF00D;
        @(negedge clk_i);
        expect_resp("rd3");
        tick; s_resp_bi = 0;
        @(negedge clk_i);
        chk("rd3_empty", 32'(dut.count), 0);
        chk("rd3_err", 32'(err_o), 0);
        tick;
        m_req_i = 1; m_addr_bi = 32'h40000000;
        @(negedge clk_i);
        chk("urd_ack", 32'(m_ack_o), 1);
        chk("urd_unm", 32'(unmapped_o), 1);
        q.push_back(32'hDEADBEEF);
        tick; m_req_i = 0;
        @(negedge clk_i);
        expect_resp("urd");
        chk("urd_unm_off", 32'(unmapped_o), 0);
        tick;
        @(negedge clk_i);
        chk("urd_resp_off", 32'(m_resp_o), 0);
        chk("urd_rdata_off", m_rdata_bo, 0);
        chk("urd_count", 32'(dut.count), 0);
        tick;
        m_req_i = 1; m_addr_bi = 32'h00000104; s_ack_bi = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("fill_ack", 32'(m_ack_o), 1);
            q.push_back(32'h1000 + i);
            tick;
        end
        @(negedge clk_i);
        chk("full_ack", 32'(m_ack_o), 0);
        chk("full_sreq", 32'(s_req_bo), 0);
        chk("full_count", 32'(dut.count), 4);
        tick; s_resp_bi = 4'b0010; s_rdata_bi[63:32] = 32'h1000;
        @(negedge clk_i);
        expect_resp("full_pop");
        chk("full_pop_ack", 32'(m_ack_o), 0);
        tick; s_resp_bi = 0;
        @(negedge clk_i);
        chk("after_pop_ack", 32'(m_ack_o), 1);
        chk("after_pop_sreq", 32'(s_req_bo), 4'b0010);
        q.push_back(32'h1004);
        tick; m_req_i = 0; s_ack_bi = 0;
        for (int i = 1; i < 5; i++) begin
            s_resp_bi = 4'b0010; s_rdata_bi[63:32] = 32'h1000 + i;
            @(negedge clk_i);
            expect_resp("drain");
            tick;
        end
        s_resp_bi = 0;
        @(negedge clk_i);
        chk("drain_count", 32'(dut.count), 0);
        chk("drain_err", 32'(err_o), 0);
        tick;
        m_req_i = 1; m_addr_bi = 32'h00000004; s_ack_bi = 4'b0001;
        @(negedge clk_i);
        chk("ooo_ack0", 32'(m_ack_o), 1);
        q.push_back(32'h0000A0A0);
        tick; m_addr_bi = 32'h00001008; s_ack_bi = 4'b0100;
        @(negedge clk_i);
        chk("ooo_ack2", 32'(m_ack_o), 1);
        chk("ooo_sreq2", 32'(s_req_bo), 4'b0100);
        q.push_back(32'h0000B0B0);
        tick; m_req_i = 0; s_ack_bi = 0; s_resp_bi = 4'b0100; s_rdata_bi[95:64] = 32'h0000B0B0;
        @(negedge clk_i);
        chk("ooo_drop_resp", 32'(m_resp_o), 0);
        chk("ooo_drop_rdata", m_rdata_bo, 0);
        tick; s_resp_bi = 0;
        @(negedge clk_i);
        chk("ooo_err", 32'(err_o), 1);
        chk("ooo_count", 32'(dut.count), 2);
        tick; s_resp_bi = 4'b0001; s_rdata_bi[31:0] = 32'h0000A0A0;
        @(negedge clk_i);
        expect_resp("ooo_s0");
        tick; s_resp_bi = 0;
        @(negedge clk_i);
        chk("ooo_left", 32'(dut.count), 1);
        tick; m_req_i = 1; m_addr_bi = 32'h80000000; s_ack_bi = 4'b1000;
        @(negedge clk_i);
        chk("pre_rst_ack", 32'(m_ack_o), 1);
        tick; m_req_i = 0; s_ack_bi = 0;
        @(negedge clk_i);
        chk("pre_rst_count", 32'(dut.count), 2);
        tick; rst_i = 1'b1;
        #2;
        chk("async_rst_count", 32'(dut.count), 0);
        chk("async_rst_err", 32'(err_o), 0);
        tick; rst_i = 1'b0;
        q.delete();
        s_resp_bi = 4'b0001;
        @(negedge clk_i);
        chk("post_rst_resp", 32'(m_resp_o), 0);
        chk("post_rst_rdata", m_rdata_bo, 0);
        tick; s_resp_bi = 0;
        @(negedge clk_i);
        chk("post_rst_err", 32'(err_o), 1);
        chk("post_rst_count", 32'(dut.count), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
